conv_pe_tiled: RTL and testbench

//  Parametrised convolution PE: K x K sliding window over Tin input channels, Tout output channels.

---
 rtl/conv_pe_tiled.sv | 162 ++++++++++++++++
 tb/tb_conv_pe_tiled.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pe_tiled.sv
// conv_pe_tiled: K x K x Tin convolution PE producing Tout output channels.
// Window, filter and control registers form stage 0; products, channel sums and the psum add follow as S1..S3.
module conv_pe_tiled #(
    parameter int K        = 3,
    parameter int Tin      = 4,
    parameter int Tout     = 4,
    parameter int W_DATA   = 8,
    parameter int W_KERNEL = 8,
    parameter int W_PSUM   = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_run,
    input  logic                                i_emit,
    input  logic                                i_mode_1x1,
    input  logic                                i_first_row,
    input  logic                                i_last_row,
    input  logic                                i_first_col,
    input  logic                                i_last_col,
    input  logic                                i_psum_en,
    input  logic                                i_reuse_filter,
    input  logic [K*Tin*W_DATA-1:0]             i_ifm,
    input  logic [Tout*K*K*Tin*W_KERNEL-1:0]    i_filter,
    input  logic [Tout*W_PSUM-1:0]              i_psum,
    output logic [Tout*W_PSUM-1:0]              o_acc,
    output logic                                o_vld
);
    localparam int IFM_DW    = Tin * W_DATA;
    localparam int FILTER_DW = K * K * Tin * W_KERNEL;
    localparam int W_PROD    = W_DATA + W_KERNEL;
    localparam int NTAP      = K * K * Tin;
    localparam int CTR       = K / 2;

    logic [K*IFM_DW-1:0]       win_r [K];
    logic [Tout*FILTER_DW-1:0] filt_r;
    logic                      v0_r, mode0_r, frow0_r, lrow0_r, fcol0_r, lcol0_r, pen0_r;
    logic [Tout*W_PSUM-1:0]    psum0_r, psum1_r, psum2_r;
    logic                      v1_r, v2_r, pen1_r, pen2_r;
    logic signed [W_PROD-1:0]  prod_s [Tout][NTAP];
    logic signed [W_PROD-1:0]  prod_r [Tout][NTAP];
    logic signed [W_PSUM-1:0]  sum_s [Tout];
    logic signed [W_PSUM-1:0]  sum_r [Tout];
    logic [Tout*W_PSUM-1:0]    acc_s;

    // Full-precision signed product; operands are sign-extended first so the multiply is exact.
    function automatic logic signed [W_PROD-1:0] mul(input logic signed [W_DATA-1:0] a,
                                                     input logic signed [W_KERNEL-1:0] b);
        logic signed [W_PROD-1:0] ax;
        logic signed [W_PROD-1:0] bx;
        ax = W_PROD'(a);
        bx = W_PROD'(b);
        return ax * bx;
    endfunction

    // 1x1 mode keeps only the centre tap and overrides padding; a single-column window has no padding.
    function automatic logic tap_keep(input int r, input int s, input logic m,
                                      input logic fr, input logic lr, input logic fc, input logic lc);
        logic keep;
        if (m) begin
            keep = (r == CTR) && (s == CTR);
        end else if (K > 1) begin
            keep = !((r == 0 && fr) || (r == K-1 && lr) || (s == 0 && fc) || (s == K-1 && lc));
        end else begin
            keep = 1'b1;
        end
        return keep;
    endfunction

    // Stage 0: window shift, filter load and control capture on i_run; the valid tag is refreshed every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < K; j++) win_r[j] <= '0;
            filt_r  <= '0;
            v0_r    <= 1'b0;
            mode0_r <= 1'b0;
            frow0_r <= 1'b0;
            lrow0_r <= 1'b0;
            fcol0_r <= 1'b0;
            lcol0_r <= 1'b0;
            pen0_r  <= 1'b0;
            psum0_r <= '0;
        end else begin
            v0_r <= i_run & i_emit;
            if (i_run) begin
                for (int j = 0; j < K-1; j++) win_r[j] <= win_r[j+1];
                win_r[K-1] <= i_ifm;
                mode0_r    <= i_mode_1x1;
                frow0_r    <= i_first_row;
                lrow0_r    <= i_last_row;
                fcol0_r    <= i_first_col;
                lcol0_r    <= i_last_col;
                pen0_r     <= i_psum_en;
                psum0_r    <= i_psum;
                if (!i_reuse_filter) filt_r <= i_filter;
            end
        end
    end

    // S1 products with padding / 1x1 masking applied per tap.
    always_comb begin
        prod_s = '{default: '0};
        for (int o = 0; o < Tout; o++)
            for (int r = 0; r < K; r++)
                for (int s = 0; s < K; s++)
                    for (int c = 0; c < Tin; c++)
                        if (tap_keep(r, s, mode0_r, frow0_r, lrow0_r, fcol0_r, lcol0_r)) begin
                            prod_s[o][(r*K+s)*Tin+c] =
                                mul(win_r[s][(r*Tin+c)*W_DATA +: W_DATA],
                                    filt_r[(((o*K+r)*K+s)*Tin+c)*W_KERNEL +: W_KERNEL]);
                        end else begin
                            prod_s[o][(r*K+s)*Tin+c] = '0;
                        end
    end

    // S2 per-output-channel reduction over all taps and input channels.
    always_comb begin
        sum_s = '{default: '0};
        for (int o = 0; o < Tout; o++) begin
            sum_s[o] = '0;
            for (int t = 0; t < NTAP; t++) sum_s[o] = sum_s[o] + W_PSUM'(prod_r[o][t]);
        end
    end

    // S3 optional psum add, wrapping modulo 2^W_PSUM.
    always_comb begin
        acc_s = '0;
        for (int o = 0; o < Tout; o++)
            if (pen2_r) begin
                acc_s[o*W_PSUM +: W_PSUM] = sum_r[o] + psum2_r[o*W_PSUM +: W_PSUM];
            end else begin
                acc_s[o*W_PSUM +: W_PSUM] = sum_r[o];
            end
    end

    // S1..S3 pipeline registers; they advance every cycle and o_acc only updates on a valid result.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r    <= 1'b0;
            v2_r    <= 1'b0;
            pen1_r  <= 1'b0;
            pen2_r  <= 1'b0;
            psum1_r <= '0;
            psum2_r <= '0;
            prod_r  <= '{default: '0};
            sum_r   <= '{default: '0};
            o_vld   <= 1'b0;
            o_acc   <= '0;
        end else begin
            v1_r    <= v0_r;
            pen1_r  <= pen0_r;
            psum1_r <= psum0_r;
            prod_r  <= prod_s;
            v2_r    <= v1_r;
            pen2_r  <= pen1_r;
            psum2_r <= psum1_r;
            sum_r   <= sum_s;
            o_vld   <= v2_r;
            if (v2_r) o_acc <= acc_s;
            else      o_acc <= o_acc;
        end
    end
endmodule

// File: tb/tb_conv_pe_tiled.sv
// Self-checking bench for conv_pe_tiled: directed table of uniform-data windows plus
// randomized streaming against an arithmetic reference model with an exact-latency scoreboard.
module tb_conv_pe_tiled;
    localparam int K    = 3;
    localparam int TIN  = 4;
    localparam int TOUT = 4;
    localparam int WD   = 8;
    localparam int WK   = 8;
    localparam int WP   = 32;
    localparam int NF   = TOUT * K * K * TIN;
    localparam int WB   = TOUT * WP;

    logic             clk, rst;
    logic             i_run, i_emit, i_mode_1x1, i_first_row, i_last_row, i_first_col, i_last_col;
    logic             i_psum_en, i_reuse_filter;
    logic [K*TIN*WD-1:0] i_ifm;
    logic [NF*WK-1:0] i_filter;
    logic [WB-1:0]    i_psum, o_acc;
    logic             o_vld;

    conv_pe_tiled #(.K(K), .Tin(TIN), .Tout(TOUT), .W_DATA(WD), .W_KERNEL(WK), .W_PSUM(WP)) dut (
        .clk(clk), .rst(rst), .i_run(i_run), .i_emit(i_emit), .i_mode_1x1(i_mode_1x1),
        .i_first_row(i_first_row), .i_last_row(i_last_row), .i_first_col(i_first_col),
        .i_last_col(i_last_col), .i_psum_en(i_psum_en), .i_reuse_filter(i_reuse_filter),
        .i_ifm(i_ifm), .i_filter(i_filter), .i_psum(i_psum), .o_acc(o_acc), .o_vld(o_vld));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [WB-1:0] acc; int due; } exp_t;
    typedef struct {
        int ifm; int w;
        logic mode; logic fr; logic lr; logic fc; logic lc; logic pen;
        logic [WP-1:0] psum; logic [WP-1:0] exp;
    } vec_t;

    exp_t          q[$];
    vec_t          vecs[10];
    int            m_win  [K][K][TIN];
    int            m_filt [TOUT][K][K][TIN];
    logic [WB-1:0] m_acc;
    int            cyc, n_tests, n_fail;

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Convolution of the current model window, straight from the masking rules.
    function automatic logic [WB-1:0] golden();
        logic [WB-1:0] res;
        longint        acc;
        bit            keep;
        res = '0;
        for (int o = 0; o < TOUT; o++) begin
            acc = 0;
            for (int r = 0; r < K; r++)
                for (int s = 0; s < K; s++)
                    for (int c = 0; c < TIN; c++) begin
                        if (i_mode_1x1) keep = (r == K/2) && (s == K/2);
                        else keep = !((r == 0 && i_first_row) || (r == K-1 && i_last_row) ||
                                      (s == 0 && i_first_col) || (s == K-1 && i_last_col));
                        if (keep) acc += longint'(m_win[r][s][c]) * longint'(m_filt[o][r][s][c]);
                    end
            if (i_psum_en) acc += longint'($signed(i_psum[o*WP +: WP]));
            res[o*WP +: WP] = acc[WP-1:0];
        end
        return res;
    endfunction

    // Apply the edge about to happen to the model, advance one cycle, then score the outputs.
    task automatic tick();
        logic exp_vld;
        if (rst) begin
            for (int r = 0; r < K; r++) for (int s = 0; s < K; s++) for (int c = 0; c < TIN; c++) begin
                m_win[r][s][c] = 0;
                for (int o = 0; o < TOUT; o++) m_filt[o][r][s][c] = 0;
            end
            q.delete();
            m_acc = '0;
        end else if (i_run) begin
            for (int s = 0; s < K-1; s++)
                for (int r = 0; r < K; r++) for (int c = 0; c < TIN; c++) m_win[r][s][c] = m_win[r][s+1][c];
            for (int r = 0; r < K; r++) for (int c = 0; c < TIN; c++)
                m_win[r][K-1][c] = int'($signed(i_ifm[(r*TIN+c)*WD +: WD]));
            if (!i_reuse_filter)
                for (int o = 0; o < TOUT; o++) for (int r = 0; r < K; r++)
                    for (int s = 0; s < K; s++) for (int c = 0; c < TIN; c++)
                        m_filt[o][r][s][c] = int'($signed(i_filter[(((o*K+r)*K+s)*TIN+c)*WK +: WK]));
            if (i_emit) q.push_back('{acc: golden(), due: cyc + 4});
        end
        @(negedge clk);
        cyc++;
        exp_vld = (q.size() > 0) && (q[0].due == cyc);
        chk("o_vld", WB'(o_vld), WB'(exp_vld));
        if (exp_vld) m_acc = q.pop_front().acc;
        chk("o_acc", o_acc, m_acc);
    endtask

    task automatic rand_data();
        for (int k = 0; k < K*TIN; k++) i_ifm[k*WD +: WD] = WD'($urandom);
        for (int o = 0; o < TOUT; o++) i_psum[o*WP +: WP] = $urandom;
        i_first_row = 1'($urandom); i_last_row = 1'($urandom);
        i_first_col = 1'($urandom); i_last_col = 1'($urandom);
        i_mode_1x1  = ($urandom_range(0, 3) == 0);
        i_psum_en   = 1'($urandom);
    endtask

    task automatic rand_filter();
        for (int k = 0; k < NF; k++) i_filter[k*WK +: WK] = WK'($urandom);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   lat;
        bit   got;
        v = vecs[idx];
        for (int k = 0; k < K*TIN; k++) i_ifm[k*WD +: WD] = WD'(v.ifm);
        for (int k = 0; k < NF; k++) i_filter[k*WK +: WK] = WK'(v.w);
        for (int o = 0; o < TOUT; o++) i_psum[o*WP +: WP] = v.psum;
        i_mode_1x1 = v.mode; i_first_row = v.fr; i_last_row = v.lr;
        i_first_col = v.fc; i_last_col = v.lc; i_psum_en = v.pen;
        i_reuse_filter = 1'b0; i_run = 1'b1; i_emit = 1'b0;
        repeat (3) tick();
        i_emit = 1'b1;
        tick();
        i_run = 1'b0; i_emit = 1'b0; i_reuse_filter = 1'b1;
        got = 1'b0; lat = 0;
        for (int k = 0; k < 8; k++) begin
            if (!got) begin
                tick();
                lat++;
                if (o_vld) begin
                    got = 1'b1;
                    chk($sformatf("vec%0d_acc", idx), o_acc, {TOUT{v.exp}});
                    chk($sformatf("vec%0d_latency", idx), WB'(lat), WB'(3));
                end
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL vec%0d_timeout cyc=%0d got=no o_vld expected=o_vld within 8 cycles", idx, cyc);
        end
    endtask

    initial begin
        int pulses;
        //          ifm   w    mode fr    lr    fc    lc    pen   psum           expected
        vecs[0] = '{1,    1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         32'd36};
        vecs[1] = '{1,    1,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,         32'd16};
        vecs[2] = '{1,    1,   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0,         32'd4};
        vecs[3] = '{1,    1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         32'd24};
        vecs[4] = '{2,    -3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd100,       32'd76};
        vecs[5] = '{2,    -3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd100,       32'd76};
        vecs[6] = '{-128, -128, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        32'd589824};
        vecs[7] = '{-128, -128, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8008_FFFF};
        vecs[8] = '{1,    1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd12345,     32'd36};
        vecs[9] = '{-1,   5,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF6, 32'hFFFF_FFA6};

        cyc = 0; n_tests = 0; n_fail = 0;
        rst = 1'b1; i_run = 1'b0; i_emit = 1'b0; i_mode_1x1 = 1'b0;
        i_first_row = 1'b0; i_last_row = 1'b0; i_first_col = 1'b0; i_last_col = 1'b0;
        i_psum_en = 1'b0; i_reuse_filter = 1'b0; i_ifm = '0; i_filter = '0; i_psum = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("reset_vld", WB'(o_vld), WB'(0));
        chk("reset_acc", o_acc, '0);

        for (int i = 0; i < 10; i++) begin
            run_vec(i);
            repeat (2) tick();
        end

        // Filter reuse: load once, then 8 back-to-back emits while i_filter carries garbage.
        rand_filter(); rand_data();
        i_reuse_filter = 1'b0; i_run = 1'b1; i_emit = 1'b0;
        repeat (2) tick();
        i_reuse_filter = 1'b1; i_emit = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            rand_data(); rand_filter();
            tick();
            pulses += int'(o_vld);
        end
        i_run = 1'b0; i_emit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(o_vld);
        end
        chk("reuse_pulses", WB'(pulses), WB'(8));

        // Randomized streaming with bubbles, occasional filter reloads, mixed modes and flags.
        for (int i = 0; i < 600; i++) begin
            rand_data();
            i_run          = ($urandom_range(0, 3) != 0);
            i_emit         = 1'($urandom);
            i_reuse_filter = ($urandom_range(0, 7) != 0);
            if (!i_reuse_filter) rand_filter();
            tick();
        end

        // Reset with emits in flight: nothing may come out afterwards.
        i_run = 1'b1; i_emit = 1'b1; i_reuse_filter = 1'b0;
        rand_data(); rand_filter();
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0; i_run = 1'b0; i_emit = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(o_vld);
        end
        chk("midreset_pulses", WB'(pulses), WB'(0));
        chk("midreset_acc", o_acc, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
